// File: rtl/axi4_to_tlul.sv
// rtl/axi4_to_tlul.sv - AXI4 slave to TL-UL host bridge
// Bursts are split into single-beat TL-UL requests with one transaction in flight.
module axi4_to_tlul #(
  parameter int DataWidth   = 64,
  parameter int AddrWidth   = 32,
  parameter int IdWidth     = 8,
  parameter int SourceWidth = 8,
  parameter int MaxSize     = 6
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [IdWidth-1:0]       axi_awid,
  input  logic [AddrWidth-1:0]     axi_awaddr,
  input  logic [7:0]               axi_awlen,
  input  logic [2:0]               axi_awsize,
  input  logic [1:0]               axi_awburst,
  input  logic                     axi_awvalid,
  output logic                     axi_awready,
  input  logic [DataWidth-1:0]     axi_wdata,
  input  logic [DataWidth/8-1:0]   axi_wstrb,
  input  logic                     axi_wlast,
  input  logic                     axi_wvalid,
  output logic                     axi_wready,
  output logic [IdWidth-1:0]       axi_bid,
  output logic [1:0]               axi_bresp,
  output logic                     axi_bvalid,
  input  logic                     axi_bready,
  input  logic [IdWidth-1:0]       axi_arid,
  input  logic [AddrWidth-1:0]     axi_araddr,
  input  logic [7:0]               axi_arlen,
  input  logic [2:0]               axi_arsize,
  input  logic [1:0]               axi_arburst,
  input  logic                     axi_arvalid,
  output logic                     axi_arready,
  output logic [IdWidth-1:0]       axi_rid,
  output logic [DataWidth-1:0]     axi_rdata,
  output logic [1:0]               axi_rresp,
  output logic                     axi_rlast,
  output logic                     axi_rvalid,
  input  logic                     axi_rready,
  output logic [AddrWidth-1:0]     tl_a_address,
  output logic [DataWidth-1:0]     tl_a_data,
  output logic [DataWidth/8-1:0]   tl_a_mask,
  output logic [2:0]               tl_a_opcode,
  output logic [MaxSize-1:0]       tl_a_size,
  output logic [SourceWidth-1:0]   tl_a_source,
  output logic                     tl_a_valid,
  input  logic                     tl_a_ready,
  input  logic [DataWidth-1:0]     tl_d_data,
  input  logic [2:0]               tl_d_opcode,
  input  logic [SourceWidth-1:0]   tl_d_source,
  input  logic [1:0]               tl_d_error,
  input  logic                     tl_d_valid,
  output logic                     tl_d_ready
);
  localparam int LaneBytes = DataWidth / 8;
  localparam int LaneBits  = $clog2(LaneBytes);

  localparam logic [2:0] OpPutFull       = 3'd0;
  localparam logic [2:0] OpPutPartial    = 3'd1;
  localparam logic [2:0] OpGet           = 3'd4;
  localparam logic [2:0] OpAccessAck     = 3'd0;
  localparam logic [2:0] OpAccessAckData = 3'd1;
  localparam logic [1:0] RespOkay        = 2'b00;
  localparam logic [1:0] RespSlverr      = 2'b10;
  localparam logic [1:0] BurstFixed      = 2'b00;
  localparam logic [1:0] BurstWrap       = 2'b10;

  typedef enum logic [3:0] {
    IDLE, W_DATA, W_REQ, W_RESP, W_DRAIN, B_RESP, R_REQ, R_RESP, R_DATA
  } state_e;

  state_e                 state;
  logic [IdWidth-1:0]     id_q;
  logic [AddrWidth-1:0]   addr_q;
  logic [7:0]             cnt_q;
  logic [2:0]             size_q;
  logic [1:0]             burst_q;
  logic                   err_q;
  logic                   prio_write_q;
  logic [DataWidth-1:0]   a_data_q;
  logic [LaneBytes-1:0]   a_mask_q;
  logic [2:0]             a_opcode_q;
  logic [DataWidth-1:0]   rdata_q;
  logic [1:0]             rresp_q;
  logic                   rlast_q;
  logic [1:0]             bresp_q;

  function automatic logic [LaneBytes-1:0] lane_mask(input logic [LaneBits-1:0] off,
                                                     input logic [2:0] sz);
    logic [2*LaneBytes-1:0] span;
    span = ((2*LaneBytes)'(1) << (32'd1 << sz)) - (2*LaneBytes)'(1);
    return LaneBytes'(span << off);
  endfunction

  function automatic logic [AddrWidth-1:0] step_addr(input logic [AddrWidth-1:0] a,
                                                     input logic [2:0] sz,
                                                     input logic [1:0] burst);
    logic [AddrWidth-1:0] inc;
    inc = AddrWidth'(1) << sz;
    if (burst == BurstFixed) return a;
    return (a & ~(inc - AddrWidth'(1))) + inc;
  endfunction

  logic                 idle, grant_w, grant_r, ill_aw, ill_ar, d_err_w, d_err_r;
  logic [AddrWidth-1:0] next_addr;
  logic                 unused_inputs;

  // Reset gates the address-channel readies so nothing is accepted while held.
  assign idle    = (state == IDLE) && !rst_i;
  assign grant_w = idle && axi_awvalid && (!axi_arvalid || prio_write_q);
  assign grant_r = idle && axi_arvalid && !grant_w;
  assign ill_aw  = (axi_awburst == BurstWrap) || (axi_awsize > 3'(LaneBits));
  assign ill_ar  = (axi_arburst == BurstWrap) || (axi_arsize > 3'(LaneBits));
  assign d_err_w = (tl_d_error != 2'b00) || (tl_d_opcode != OpAccessAck);
  assign d_err_r = (tl_d_error != 2'b00) || (tl_d_opcode != OpAccessAckData);
  assign next_addr     = step_addr(addr_q, size_q, burst_q);
  assign unused_inputs = ^{axi_wlast, tl_d_source};

  assign axi_awready  = grant_w;
  assign axi_arready  = grant_r;
  assign axi_wready   = (state == W_DATA) || (state == W_DRAIN);
  assign tl_a_valid   = (state == W_REQ) || (state == R_REQ);
  assign tl_d_ready   = (state == W_RESP) || (state == R_RESP);
  assign axi_bvalid   = (state == B_RESP);
  assign axi_rvalid   = (state == R_DATA);
  assign axi_bid      = id_q;
  assign axi_bresp    = bresp_q;
  assign axi_rid      = id_q;
  assign axi_rdata    = rdata_q;
  assign axi_rresp    = rresp_q;
  assign axi_rlast    = rlast_q;
  assign tl_a_address = addr_q;
  assign tl_a_data    = a_data_q;
  assign tl_a_mask    = a_mask_q;
  assign tl_a_opcode  = a_opcode_q;
  assign tl_a_size    = MaxSize'(size_q);
  assign tl_a_source  = SourceWidth'(id_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      id_q         <= '0;
      addr_q       <= '0;
      cnt_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      err_q        <= 1'b0;
      prio_write_q <= 1'b1;
      a_data_q     <= '0;
      a_mask_q     <= '0;
      a_opcode_q   <= '0;
      rdata_q      <= '0;
      rresp_q      <= '0;
      rlast_q      <= 1'b0;
      bresp_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          // The pointer only moves when both channels contend.
          if (axi_awvalid && axi_arvalid) prio_write_q <= !grant_w;
          if (grant_w) begin
            id_q    <= axi_awid;
            addr_q  <= axi_awaddr;
            cnt_q   <= axi_awlen;
            size_q  <= axi_awsize;
            burst_q <= axi_awburst;
            err_q   <= ill_aw;
            state   <= ill_aw ? W_DRAIN : W_DATA;
          end else if (grant_r) begin
            id_q    <= axi_arid;
            addr_q  <= axi_araddr;
            cnt_q   <= axi_arlen;
            size_q  <= axi_arsize;
            burst_q <= axi_arburst;
            err_q   <= ill_ar;
            if (ill_ar) begin
              rdata_q <= '0;
              rresp_q <= RespSlverr;
              rlast_q <= (axi_arlen == 8'd0);
              state   <= R_DATA;
            end else begin
              a_opcode_q <= OpGet;
              a_mask_q   <= lane_mask(axi_araddr[LaneBits-1:0], axi_arsize);
              state      <= R_REQ;
            end
          end
        end
        W_DATA: if (axi_wvalid) begin
          a_data_q   <= axi_wdata;
          a_mask_q   <= axi_wstrb;
          a_opcode_q <= (axi_wstrb == lane_mask(addr_q[LaneBits-1:0], size_q)) ?
                        OpPutFull : OpPutPartial;
          state      <= W_REQ;
        end
        W_REQ: if (tl_a_ready) state <= W_RESP;
        W_RESP: if (tl_d_valid) begin
          err_q <= err_q || d_err_w;
          if (cnt_q == 8'd0) begin
            bresp_q <= (err_q || d_err_w) ? RespSlverr : RespOkay;
            state   <= B_RESP;
          end else begin
            cnt_q  <= cnt_q - 8'd1;
            addr_q <= next_addr;
            state  <= W_DATA;
          end
        end
        W_DRAIN: if (axi_wvalid) begin
          if (cnt_q == 8'd0) begin
            bresp_q <= RespSlverr;
            state   <= B_RESP;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        B_RESP: if (axi_bready) state <= IDLE;
        R_REQ: if (tl_a_ready) state <= R_RESP;
        R_RESP: if (tl_d_valid) begin
          rdata_q <= tl_d_data;
          rresp_q <= d_err_r ? RespSlverr : RespOkay;
          rlast_q <= (cnt_q == 8'd0);
          state   <= R_DATA;
        end
        R_DATA: if (axi_rready) begin
          if (cnt_q == 8'd0) begin
            state <= IDLE;
          end else begin
            cnt_q  <= cnt_q - 8'd1;
            addr_q <= next_addr;
            if (err_q) begin
              rlast_q <= (cnt_q == 8'd1);
            end else begin
              a_mask_q <= lane_mask(next_addr[LaneBits-1:0], size_q);
              state    <= R_REQ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_to_tlul.sv
// tb/tb_axi4_to_tlul.sv - randomized self-checking bench for axi4_to_tlul
// A transaction-level model predicts every A request, R beat and B response.
module tb_axi4_to_tlul;
  logic        clk = 1'b0;
  logic        rst_i;
  logic [7:0]  axi_awid, axi_arid, axi_bid, axi_rid;
  logic [31:0] axi_awaddr, axi_araddr, tl_a_address;
  logic [7:0]  axi_awlen, axi_arlen;
  logic [2:0]  axi_awsize, axi_arsize;
  logic [1:0]  axi_awburst, axi_arburst, axi_bresp, axi_rresp, tl_d_error;
  logic        axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready;
  logic        axi_bvalid, axi_bready, axi_arvalid, axi_arready;
  logic        axi_rlast, axi_rvalid, axi_rready;
  logic [63:0] axi_wdata, axi_rdata, tl_a_data, tl_d_data;
  logic [7:0]  axi_wstrb, tl_a_mask, tl_a_source, tl_d_source;
  logic [2:0]  tl_a_opcode, tl_d_opcode;
  logic [5:0]  tl_a_size;
  logic        tl_a_valid, tl_a_ready, tl_d_valid, tl_d_ready;

  int n_checks = 0;
  int n_fail = 0;
  int a_cycles = 0;
  int r_cycles = 0;

  localparam int S_AWREADY = 0, S_WREADY = 1, S_ARREADY = 2, S_AVALID = 3;
  localparam int S_DREADY = 4, S_BVALID = 5, S_RVALID = 6;

  axi4_to_tlul dut (
    .clk_i(clk), .rst_i(rst_i),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .tl_a_address(tl_a_address), .tl_a_data(tl_a_data), .tl_a_mask(tl_a_mask),
    .tl_a_opcode(tl_a_opcode), .tl_a_size(tl_a_size), .tl_a_source(tl_a_source),
    .tl_a_valid(tl_a_valid), .tl_a_ready(tl_a_ready),
    .tl_d_data(tl_d_data), .tl_d_opcode(tl_d_opcode), .tl_d_source(tl_d_source),
    .tl_d_error(tl_d_error), .tl_d_valid(tl_d_valid), .tl_d_ready(tl_d_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tl_a_valid) a_cycles++;
    if (axi_rvalid) r_cycles++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached with %0d failures so far", n_fail);
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic sig(input int s);
    case (s)
      S_AWREADY: return axi_awready;
      S_WREADY:  return axi_wready;
      S_ARREADY: return axi_arready;
      S_AVALID:  return tl_a_valid;
      S_DREADY:  return tl_d_ready;
      S_BVALID:  return axi_bvalid;
      default:   return axi_rvalid;
    endcase
  endfunction

  task automatic wait_for(input int s, input string tag);
    int n;
    n = 0;
    #1;
    while (!sig(s) && n < 64) begin
      @(negedge clk); #1;
      n++;
    end
    check_eq(tag, sig(s), 1);
  endtask

  function automatic logic [7:0] exp_mask(input logic [31:0] a, input int sz);
    int bytes, off, m;
    bytes = 1 << sz;
    off   = a % 8;
    m     = ((1 << bytes) - 1) << off;
    return m[7:0];
  endfunction

  function automatic logic [31:0] exp_next(input logic [31:0] a, input int sz, input int burst);
    longint bytes, n;
    if (burst == 0) return a;
    bytes = longint'(1) << sz;
    n = (longint'(a) / bytes) * bytes + bytes;
    return n[31:0];
  endfunction

  task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input int len,
                          input int size, input int burst, input bit fixed,
                          input logic [63:0] fdata, input logic [7:0] fstrb, input int err_beat);
    logic [31:0] a;
    logic [63:0] d;
    logic [7:0]  s, m;
    logic [1:0]  derr;
    logic [2:0]  dop;
    bit          illegal, exp_err;
    int          a_start;
    a = addr;
    illegal = (burst == 2) || (size > 3);
    exp_err = illegal;
    axi_awid = id; axi_awaddr = addr; axi_awlen = 8'(len);
    axi_awsize = 3'(size); axi_awburst = 2'(burst); axi_awvalid = 1'b1;
    wait_for(S_AWREADY, "aw_ready");
    @(posedge clk); @(negedge clk);
    axi_awvalid = 1'b0;
    a_start = a_cycles;
    for (int b = 0; b <= len; b++) begin
      m = exp_mask(a, size);
      if (fixed) begin
        d = fdata; s = fstrb;
      end else begin
        d = {$urandom, $urandom};
        s = ($urandom_range(0, 1) != 0) ? m : 8'($urandom);
      end
      axi_wdata = d; axi_wstrb = s; axi_wlast = (b == len); axi_wvalid = 1'b1;
      wait_for(S_WREADY, "w_ready");
      @(posedge clk); @(negedge clk);
      axi_wvalid = 1'b0;
      if (!illegal) begin
        check_eq("w_a_valid_latency", tl_a_valid, 1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        wait_for(S_AVALID, "w_a_valid");
        check_eq("w_a_address", tl_a_address, a);
        check_eq("w_a_opcode", tl_a_opcode, (s == m) ? 0 : 1);
        check_eq("w_a_mask", tl_a_mask, s);
        check_eq("w_a_data", tl_a_data, d);
        check_eq("w_a_size", tl_a_size, size);
        check_eq("w_a_source", tl_a_source, id);
        tl_a_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        tl_a_ready = 1'b0;
        derr = 2'b00; dop = 3'd0;
        if (fixed) begin
          if (b == err_beat) derr = 2'b01;
        end else begin
          if ($urandom_range(0, 5) == 0) derr = 2'($urandom_range(1, 3));
          if ($urandom_range(0, 9) == 0) dop = 3'd1;
        end
        exp_err = exp_err || (derr != 0) || (dop != 0);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        tl_d_error = derr; tl_d_opcode = dop; tl_d_source = id;
        tl_d_data = 64'($urandom); tl_d_valid = 1'b1;
        wait_for(S_DREADY, "w_d_ready");
        @(posedge clk); @(negedge clk);
        tl_d_valid = 1'b0;
        if (b == len) check_eq("b_valid_latency", axi_bvalid, 1);
        a = exp_next(a, size, burst);
      end
    end
    repeat ($urandom_range(0, 2)) @(negedge clk);
    wait_for(S_BVALID, "b_valid");
    check_eq("b_id", axi_bid, id);
    check_eq("b_resp", axi_bresp, exp_err ? 2 : 0);
    axi_bready = 1'b1;
    @(posedge clk); @(negedge clk);
    axi_bready = 1'b0;
    check_eq("b_valid_drop", axi_bvalid, 0);
    if (illegal) check_eq("w_illegal_no_tl", a_cycles - a_start, 0);
  endtask

  task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input int len,
                         input int size, input int burst, input bit fixed, input logic [63:0] fbase);
    logic [31:0] a;
    logic [63:0] d, exp_data;
    logic [1:0]  derr, exp_resp;
    logic [2:0]  dop;
    bit          illegal;
    int          a_start;
    a = addr;
    illegal = (burst == 2) || (size > 3);
    axi_arid = id; axi_araddr = addr; axi_arlen = 8'(len);
    axi_arsize = 3'(size); axi_arburst = 2'(burst); axi_arvalid = 1'b1;
    wait_for(S_ARREADY, "ar_ready");
    @(posedge clk); @(negedge clk);
    axi_arvalid = 1'b0;
    a_start = a_cycles;
    for (int b = 0; b <= len; b++) begin
      if (!illegal) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        wait_for(S_AVALID, "r_a_valid");
        check_eq("r_a_address", tl_a_address, a);
        check_eq("r_a_opcode", tl_a_opcode, 4);
        check_eq("r_a_mask", tl_a_mask, exp_mask(a, size));
        check_eq("r_a_size", tl_a_size, size);
        check_eq("r_a_source", tl_a_source, id);
        tl_a_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        tl_a_ready = 1'b0;
        derr = 2'b00; dop = 3'd1;
        if (fixed) begin
          d = fbase + 64'(b);
        end else begin
          d = {$urandom, $urandom};
          if ($urandom_range(0, 5) == 0) derr = 2'($urandom_range(1, 3));
          if ($urandom_range(0, 9) == 0) dop = 3'd0;
        end
        exp_data = d;
        exp_resp = ((derr != 0) || (dop != 1)) ? 2'b10 : 2'b00;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        tl_d_error = derr; tl_d_opcode = dop; tl_d_source = id;
        tl_d_data = d; tl_d_valid = 1'b1;
        wait_for(S_DREADY, "r_d_ready");
        @(posedge clk); @(negedge clk);
        tl_d_valid = 1'b0;
        check_eq("r_valid_latency", axi_rvalid, 1);
      end else begin
        exp_data = '0;
        exp_resp = 2'b10;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      wait_for(S_RVALID, "r_valid");
      check_eq("r_id", axi_rid, id);
      check_eq("r_data", axi_rdata, exp_data);
      check_eq("r_resp", axi_rresp, exp_resp);
      check_eq("r_last", axi_rlast, b == len);
      axi_rready = 1'b1;
      @(posedge clk); @(negedge clk);
      axi_rready = 1'b0;
      a = exp_next(a, size, burst);
    end
    check_eq("r_valid_drop", axi_rvalid, 0);
    if (illegal) check_eq("r_illegal_no_tl", a_cycles - a_start, 0);
  endtask

  task automatic set_pair(input logic [7:0] wid, input logic [7:0] rid);
    axi_awid = wid; axi_awaddr = 32'h100; axi_awlen = 8'd0; axi_awsize = 3'd3;
    axi_awburst = 2'b01; axi_awvalid = 1'b1;
    axi_arid = rid; axi_araddr = 32'h200; axi_arlen = 8'd0; axi_arsize = 3'd3;
    axi_arburst = 2'b01; axi_arvalid = 1'b1;
  endtask

  logic [7:0]  r_id;
  logic [31:0] r_addr;
  int          r_len, r_size, r_burst, r_start;

  initial begin
    rst_i = 1'b1;
    axi_wdata = '0; axi_wstrb = '0; axi_wlast = 1'b0; axi_wvalid = 1'b0;
    axi_bready = 1'b0; axi_rready = 1'b0; tl_a_ready = 1'b0;
    tl_d_data = '0; tl_d_opcode = '0; tl_d_source = '0; tl_d_error = '0; tl_d_valid = 1'b0;
    set_pair(8'h11, 8'h12);
    repeat (3) @(negedge clk);
    check_eq("rst_valids", {tl_a_valid, tl_d_ready, axi_bvalid, axi_rvalid,
                            axi_wready, axi_awready, axi_arready}, 0);
    check_eq("rst_a_payload", {tl_a_address, tl_a_opcode, tl_a_mask, tl_a_size, tl_a_source}, 0);
    check_eq("rst_a_data", tl_a_data, 0);
    check_eq("rst_r_data", axi_rdata, 0);
    check_eq("rst_rb_payload", {axi_rid, axi_rresp, axi_rlast, axi_bid, axi_bresp}, 0);

    rst_i = 1'b0;
    #1;
    check_eq("pair1_awready", axi_awready, 1);
    check_eq("pair1_arready", axi_arready, 0);
    do_write(8'h11, 32'h100, 0, 3, 1, 0, '0, '0, -1);
    do_read(8'h12, 32'h200, 0, 3, 1, 0, '0);
    set_pair(8'h21, 8'h22);
    #1;
    check_eq("pair2_arready", axi_arready, 1);
    check_eq("pair2_awready", axi_awready, 0);
    do_read(8'h22, 32'h200, 0, 3, 1, 0, '0);
    do_write(8'h21, 32'h100, 0, 3, 1, 0, '0, '0, -1);

    do_write(8'h05, 32'h1000, 0, 3, 1, 1, 64'hA5A5A5A5A5A5A5A5, 8'hFF, -1);
    do_read(8'h02, 32'h2000, 3, 3, 1, 1, 64'hB0);
    do_write(8'h07, 32'h3004, 0, 2, 1, 1, 64'h1122334455667788, 8'hF0, -1);
    do_write(8'h07, 32'h3004, 0, 2, 1, 1, 64'h1122334455667788, 8'h30, -1);
    do_write(8'h09, 32'h4000, 1, 3, 1, 1, 64'hCAFEF00DCAFEF00D, 8'hFF, 0);
    do_read(8'h0A, 32'h5000, 1, 3, 2, 1, '0);
    do_write(8'h0B, 32'h6000, 2, 3, 2, 1, 64'h0, 8'hFF, -1);
    do_read(8'h0C, 32'h7008, 2, 2, 0, 1, 64'hD0);
    do_read(8'h0D, 32'hFFFFFFF8, 1, 3, 1, 1, 64'hE0);

    for (int i = 0; i < 30; i++) begin
      r_id = 8'($urandom);
      r_len = $urandom_range(0, 3);
      r_size = $urandom_range(0, 3);
      r_burst = $urandom_range(0, 1);
      if ($urandom_range(0, 9) == 0) r_burst = 2;
      if ($urandom_range(0, 11) == 0) r_size = $urandom_range(4, 7);
      r_addr = $urandom;
      if ($urandom_range(0, 7) == 0) r_addr = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
      if ($urandom_range(0, 1) != 0) do_write(r_id, r_addr, r_len, r_size, r_burst, 0, '0, '0, -1);
      else do_read(r_id, r_addr, r_len, r_size, r_burst, 0, '0);
    end

    // Reset in the middle of a read response phase.
    axi_arid = 8'h33; axi_araddr = 32'h8000; axi_arlen = 8'd1; axi_arsize = 3'd3;
    axi_arburst = 2'b01; axi_arvalid = 1'b1;
    wait_for(S_ARREADY, "rr_ar_ready");
    @(posedge clk); @(negedge clk);
    axi_arvalid = 1'b0;
    wait_for(S_AVALID, "rr_a_valid");
    tl_a_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    tl_a_ready = 1'b0;
    check_eq("rr_d_ready", tl_d_ready, 1);
    r_start = r_cycles;
    #2 rst_i = 1'b1;
    #1;
    check_eq("rr_async_valids", {tl_a_valid, tl_d_ready, axi_bvalid, axi_rvalid, axi_wready}, 0);
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("rr_no_r_beat", r_cycles - r_start, 0);

    set_pair(8'h41, 8'h42);
    #1;
    check_eq("pair3_awready", axi_awready, 1);
    check_eq("pair3_arready", axi_arready, 0);
    do_write(8'h41, 32'h100, 0, 3, 1, 0, '0, '0, -1);
    do_read(8'h42, 32'h200, 0, 3, 1, 0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
